block_interleaver: RTL and testbench

Ping-pong block interleaver for the serial coded-bit chain. It sits between the socket fed by the P2S stage and the socket feeding the convolutional encoder. It collects COLS Hamming codewords of ROWS bits each, arriving serially, and re-emits them column-wise: bit i of every codeword, then bit i+1. Two banks let one block fill while the previous one drains, so throughput is one bit per cycle.

---
 rtl/interleaver_pkg.sv | 20 ++
 rtl/interleaver_bank.sv | 49 ++++
 rtl/block_interleaver.sv | 100 ++++++++++
 tb/tb_block_interleaver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// Shared types and sizing helpers for the ping-pong block interleaver.
// Latency: none (package only); backpressure: n/a.
package interleaver_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int ROWS_DEF = 7;
  localparam int COLS_DEF = 4;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interleaver_bank.sv
// One interleaver bank: N-entry symbol store plus its EMPTY/FILLING/FULL/DRAINING state.
// Latency: writes land on the edge, reads are combinational from rd_addr; the top stalls via state.
module interleaver_bank
  import interleaver_pkg::*;
#(
  parameter int N          = 28,
  parameter int DATA_WIDTH = 1,
  parameter int AW         = cnt_width(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  wr_last,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_last,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output bank_state_t           state
);

  logic [DATA_WIDTH-1:0] mem [N];
  bank_state_t           state_nxt;

  // Contents need no reset: a bank is only read once its state says FULL.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:    if (wr_en) state_nxt = wr_last ? FULL : FILLING;
      FILLING:  if (wr_en && wr_last) state_nxt = FULL;
      FULL:     if (rd_en) state_nxt = rd_last ? EMPTY : DRAINING;
      DRAINING: if (rd_en && rd_last) state_nxt = EMPTY;
      default:  state_nxt = EMPTY;
    endcase
  end

endmodule

// File: rtl/block_interleaver.sv
// Ping-pong row-in/column-out block interleaver; one bank fills while the other drains.
// Latency: o_valid one cycle after a block's last accept; o_data/o_valid hold while i_ready is low.
module block_interleaver
  import interleaver_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int N  = ROWS * COLS;
  localparam int AW = cnt_width(N);
  localparam int RW = cnt_width(ROWS);
  localparam int CW = cnt_width(COLS);

  logic                  wsel, rsel;
  logic [AW-1:0]         wcnt, raddr;
  logic [RW-1:0]         ri;
  logic [CW-1:0]         rj;
  logic                  w_acc, r_acc, w_last, r_last;
  bank_state_t           st   [2];
  logic [DATA_WIDTH-1:0] rdat [2];

  // Handshakes decode registered bank state only, never the partner's valid/ready.
  assign o_ready = (st[wsel] == EMPTY) || (st[wsel] == FILLING);
  assign o_valid = (st[rsel] == FULL)  || (st[rsel] == DRAINING);
  assign o_data  = o_valid ? rdat[rsel] : '0;

  assign w_acc  = i_valid && o_ready;
  assign r_acc  = o_valid && i_ready;
  assign w_last = (wcnt == AW'(N - 1));
  assign r_last = (ri == RW'(ROWS - 1)) && (rj == CW'(COLS - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    interleaver_bank #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW)
    ) u_bank (
      .clk     (i_clk),
      .rst     (i_rst),
      .wr_en   (w_acc && (wsel == 1'(b))),
      .wr_addr (wcnt),
      .wr_dat  (i_data),
      .wr_last (w_last),
      .rd_en   (r_acc && (rsel == 1'(b))),
      .rd_addr (raddr),
      .rd_last (r_last),
      .rd_dat  (rdat[b]),
      .state   (st[b])
    );
  end

  // raddr tracks rj*ROWS + ri incrementally: +ROWS per column step, restart at ri+1 per row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wsel  <= 1'b0;
      rsel  <= 1'b0;
      wcnt  <= '0;
      raddr <= '0;
      ri    <= '0;
      rj    <= '0;
    end else begin
      if (w_acc) begin
        if (w_last) begin
          wcnt <= '0;
          wsel <= ~wsel;
        end else begin
          wcnt <= wcnt + AW'(1);
        end
      end
      if (r_acc) begin
        if (rj == CW'(COLS - 1)) begin
          rj <= '0;
          if (ri == RW'(ROWS - 1)) begin
            ri    <= '0;
            raddr <= '0;
            rsel  <= ~rsel;
          end else begin
            ri    <= ri + RW'(1);
            raddr <= AW'(ri) + AW'(1);
          end
        end else begin
          rj    <= rj + CW'(1);
          raddr <= raddr + AW'(ROWS);
        end
      end
    end
  end

endmodule

// File: tb/tb_block_interleaver.sv
// Directed and table-driven bench for block_interleaver (7x4x1 and 3x2x4 instances).
// Latency/backpressure expectations come from a reference permutation model.
module tb_block_interleaver;

  localparam int ROWS = 7;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  typedef struct {
    logic [3:0] din;
    logic [3:0] dexp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, din, iv, ordy, dout, ov, irdy;
  logic       s_rst, s_iv, s_ordy, s_ov, s_irdy;
  logic [3:0] s_din, s_dout;

  block_interleaver #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(iv),
    .o_ready(ordy), .o_data(dout), .o_valid(ov), .i_ready(irdy)
  );

  block_interleaver #(.ROWS(3), .COLS(2), .DATA_WIDTH(4)) dut_s (
    .i_clk(clk), .i_rst(s_rst), .i_data(s_din), .i_valid(s_iv),
    .o_ready(s_ordy), .o_data(s_dout), .o_valid(s_ov), .i_ready(s_irdy)
  );

  int   checks = 0;
  int   errors = 0;
  logic in_q[$];
  int   oc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; applies inputs, scores any transfer, advances one cycle.
  task automatic step(input logic v, input logic d, input logic r);
    int b, m, i, j, idx;
    iv = v; din = d; irdy = r;
    if (v && ordy) in_q.push_back(d);
    if (ov && r) begin
      b = oc / N; m = oc % N; i = m / COLS; j = m % COLS;
      idx = b * N + j * ROWS + i;
      chk("perm_avail", 32'(idx < in_q.size()), 1);
      if (idx < in_q.size()) chk("perm_data", dout, in_q[idx]);
      oc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; iv = 1'b0; irdy = 1'b0; din = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", ov, 0);
    chk("rst_data", dout, 0);
    chk("rst_ready", ordy, 1);
    rst = 1'b0;
    in_q.delete();
    oc = 0;
  endtask

  vec_t t1[N];
  vec_t s_tab[6];

  initial begin
    int   drops, bubbles, unstable, early, cyc, k;
    logic held;

    rst = 1'b1; s_rst = 1'b1; iv = 0; din = 0; irdy = 0;
    s_iv = 0; s_din = '0; s_irdy = 0;
    for (int n = 0; n < N; n++) begin
      t1[n].din  = (n < ROWS) ? 4'd1 : 4'd0;
      t1[n].dexp = (n % COLS == 0) ? 4'd1 : 4'd0;
    end
    s_tab[0] = '{4'd0, 4'd0}; s_tab[1] = '{4'd1, 4'd3};
    s_tab[2] = '{4'd2, 4'd1}; s_tab[3] = '{4'd3, 4'd4};
    s_tab[4] = '{4'd4, 4'd2}; s_tab[5] = '{4'd5, 4'd5};
    @(posedge clk); #1;
    s_rst = 1'b0;

    // Codeword 0 all ones, others zero.
    do_reset();
    for (int n = 0; n < N; n++) begin
      if (n == N - 1) chk("t1_valid_pre", ov, 0);
      step(1'b1, t1[n].din[0], 1'b1);
    end
    chk("t1_valid_rise", ov, 1);
    for (int m = 0; m < N; m++) begin
      chk("t1_out", dout, t1[m].dexp[0]);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("t1_valid_end", ov, 0);
    chk("t1_data_end", dout, 0);
    chk("t1_count", oc, N);

    // Two back-to-back random blocks.
    do_reset();
    drops = 0; bubbles = 0;
    for (int c = 0; c < 3 * N; c++) begin
      if (!ordy) drops++;
      if (c >= N && !ov) bubbles++;
      step(c < 2 * N, 1'($urandom_range(0, 1)), 1'b1);
    end
    chk("b2b_ready_drops", drops, 0);
    chk("b2b_bubbles", bubbles, 0);
    chk("b2b_count", oc, 2 * N);

    // Downstream stalled while two blocks are offered.
    do_reset();
    drops = 0; unstable = 0; held = 1'b0;
    for (int c = 0; c < 2 * N; c++) begin
      if (!ordy) drops++;
      if (c == N) held = dout;
      if (c >= N && (ov !== 1'b1 || dout !== held)) unstable++;
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("bp_ready_drops", drops, 0);
    chk("bp_unstable", unstable, 0);
    chk("bp_head", dout, in_q[0]);
    chk("bp_ready_low", ordy, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("bp_no_accept", in_q.size(), 2 * N);
    early = 0;
    for (int c = 0; c < N; c++) begin
      if (ordy) early++;
      step(1'b0, 1'b0, 1'b1);
    end
    chk("bp_ready_early", early, 0);
    chk("bp_ready_back", ordy, 1);
    for (int c = 0; c < N; c++) step(1'b0, 1'b0, 1'b1);
    chk("bp_count", oc, 2 * N);

    // Random handshakes over ten blocks.
    do_reset();
    cyc = 0;
    while ((in_q.size() < 10 * N || oc < 10 * N) && cyc < 4000) begin
      step((in_q.size() < 10 * N) && 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_in", in_q.size(), 10 * N);
    chk("rand_out", oc, 10 * N);

    // Asynchronous reset while block 0 drains and block 1 fills.
    do_reset();
    for (int c = 0; c < N + 13; c++) step(1'b1, 1'b1, 1'b1);
    iv = 1'b0; irdy = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", ov, 0);
    chk("arst_ready", ordy, 1);
    chk("arst_data", dout, 0);
    in_q.delete();
    oc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < N; n++) step(1'b1, 1'(n % 3 == 0), 1'b1);
    for (int m = 0; m < N; m++) step(1'b0, 1'b0, 1'b1);
    chk("arst_new_block", oc, N);
    chk("arst_idle", ov, 0);

    // 3x2 instance with 4-bit symbols.
    s_irdy = 1'b0;
    for (int n = 0; n < 6; n++) begin
      s_iv = 1'b1; s_din = s_tab[n].din;
      @(posedge clk); #1;
    end
    s_iv = 1'b0; s_irdy = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      if (s_ov) begin
        chk("small_out", s_dout, s_tab[k].dexp);
        k++;
      end
      @(posedge clk); #1;
    end
    chk("small_count", k, 6);
    chk("small_idle", s_ov, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
